// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART register port.
//   - register address map (TX data, status, RX data)
//   - status register bit indices
//   - state encoding of the poll/decide bus-master FSM
package uart_pkg;

   localparam logic [1:0] UART_ADDR_TX     = 2'd0;
   localparam logic [1:0] UART_ADDR_STATUS = 2'd1;
   localparam logic [1:0] UART_ADDR_RX     = 2'd2;

   localparam int unsigned ST_TX_BUSY  = 0;
   localparam int unsigned ST_RX_AVAIL = 1;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      DECIDE,
      TX_WR,
      RX_RD,
      GAP
   } state_t;

endpackage

// File: rtl/uart_wb_master_if.sv
// uart_wb_master_if: Wishbone-style register bus between the bus master and
// the UART core.
//   wb_addr     master->slave  register address
//   wb_data_out master->slave  write data
//   wb_data_in  slave->master  read data
//   wb_we       master->slave  1 = write, 0 = read
//   wb_stb      master->slave  cycle strobe
//   wb_ack      slave->master  acknowledge
interface uart_wb_master_if;
   logic [1:0] wb_addr;
   logic [7:0] wb_data_out;
   logic [7:0] wb_data_in;
   logic       wb_we;
   logic       wb_stb;
   logic       wb_ack;

   modport master (
      output wb_addr, wb_data_out, wb_we, wb_stb,
      input  wb_data_in, wb_ack
   );

   modport slave (
      input  wb_addr, wb_data_out, wb_we, wb_stb,
      output wb_data_in, wb_ack
   );
endinterface

// File: rtl/uart_wb_master_wb_cycle_ctl.sv
// wb_cycle_ctl: runs one bus transaction at a time.
//   clk, reset : bus clock, synchronous active-high reset
//   start      : launch a transaction this edge (addr/we/data sampled)
//   addr/we/data : transaction request
//   done       : ack sampled this cycle (combinational, strobe qualified)
//   rdata      : read data, valid while done is high
//   timeout    : ACK_TIMEOUT strobe cycles elapsed without ack
//   wb         : bus master port
module wb_cycle_ctl
   import uart_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [7:0]       data,
   output logic             done,
   output logic [7:0]       rdata,
   output logic             timeout,
   uart_wb_master_if.master wb
);

   logic [7:0] wait_cnt;

   // An ack with the strobe low is not part of any cycle and is ignored.
   assign done    = wb.wb_stb && wb.wb_ack;
   assign rdata   = wb.wb_data_in;
   // Counter is 0 in the first strobe cycle, so the strobe stays up exactly
   // ACK_TIMEOUT cycles. An ack in the final cycle wins over the timeout.
   assign timeout = wb.wb_stb && !wb.wb_ack && (wait_cnt == 8'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wb.wb_stb      <= 1'b0;
         wb.wb_we       <= 1'b0;
         wb.wb_addr     <= '0;
         wb.wb_data_out <= '0;
         wait_cnt       <= '0;
      end else if (start) begin
         wb.wb_stb  <= 1'b1;
         wb.wb_addr <= addr;
         wb.wb_we   <= we;
         wait_cnt   <= '0;
         if (we) begin
            wb.wb_data_out <= data;
         end
      end else if (done || timeout) begin
         wb.wb_stb <= 1'b0;
         wb.wb_we  <= 1'b0;
      end else if (wb.wb_stb) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/uart_wb_master.sv
// uart_wb_master: polls the UART status register, writes bytes from the TX
// stream into TX_DATA and forwards bytes read from RX_DATA as pulses.
//   clk, reset  : bus clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready : byte stream in; tx_ready pulses on write ack
//   rx_data/rx_valid          : received byte and its one-cycle pulse
//   timeout_err : one-cycle pulse when a bus cycle is abandoned
//   wb          : register bus master port
module uart_wb_master
   import uart_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 15,
   parameter int unsigned POLL_GAP    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             timeout_err,
   uart_wb_master_if.master wb
);

   state_t     state, state_next;
   logic [1:0] status_q;
   logic [7:0] gap_cnt;
   logic       start;
   logic [1:0] bus_addr;
   logic       bus_we;
   logic       done;
   logic       timeout;
   logic [7:0] rdata;

   wb_cycle_ctl #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_cycle (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .addr    (bus_addr),
      .we      (bus_we),
      .data    (tx_data),
      .done    (done),
      .rdata   (rdata),
      .timeout (timeout),
      .wb      (wb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         status_q    <= '0;
         gap_cnt     <= '0;
         rx_data     <= '0;
         tx_ready    <= 1'b0;
         rx_valid    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_next;
         gap_cnt     <= (state == GAP) ? gap_cnt + 8'd1 : '0;
         tx_ready    <= (state == TX_WR) && done;
         rx_valid    <= (state == RX_RD) && done;
         timeout_err <= timeout;
         if (state == POLL && done) begin
            status_q[ST_TX_BUSY]  <= rdata[ST_TX_BUSY];
            status_q[ST_RX_AVAIL] <= rdata[ST_RX_AVAIL];
         end
         if (state == RX_RD && done) begin
            rx_data <= rdata;
         end
      end
   end

   // start is raised on the transition into a bus state so the strobe comes
   // up on the same edge that enters that state.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      bus_addr   = UART_ADDR_STATUS;
      bus_we     = 1'b0;
      unique case (state)
         IDLE: begin
            state_next = POLL;
            start      = 1'b1;
         end
         POLL: begin
            if (done) begin
               state_next = DECIDE;
            end else if (timeout) begin
               state_next = GAP;
            end
         end
         DECIDE: begin
            if (status_q[ST_RX_AVAIL]) begin
               state_next = RX_RD;
               start      = 1'b1;
               bus_addr   = UART_ADDR_RX;
            end else if (tx_valid && !status_q[ST_TX_BUSY]) begin
               state_next = TX_WR;
               start      = 1'b1;
               bus_addr   = UART_ADDR_TX;
               bus_we     = 1'b1;
            end else begin
               state_next = GAP;
            end
         end
         TX_WR, RX_RD: begin
            if (done || timeout) begin
               state_next = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == 8'(POLL_GAP)) begin
               state_next = POLL;
               start      = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_wb_master.sv
module tb_uart_wb_master;
   import uart_pkg::*;

   localparam int unsigned ACK_TO = 15;
   localparam int unsigned GAP_N  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       timeout_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // slave model state
   bit         stall_all = 1'b0;
   bit         stall_wr  = 1'b0;
   int         poll_cnt   = 0;
   int         busy_until = 0;
   int         rx_set = 0;
   int         rx_clr = 0;
   logic [7:0] slv_rx = 8'h00;
   logic [7:0] rd;

   typedef enum logic [1:0] {EV_WR, EV_TXR, EV_RXV, EV_TMO} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [1:0] addr;
      logic [7:0] data;
   } ev_t;
   ev_t exp_q[$];

   uart_wb_master_if wb();

   uart_wb_master #(
      .ACK_TIMEOUT(ACK_TO),
      .POLL_GAP   (GAP_N)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .timeout_err (timeout_err),
      .wb          (wb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // zero-wait slave with optional stalls
   assign wb.wb_ack = wb.wb_stb && !stall_all && !(stall_wr && wb.wb_we);
   always_comb begin
      rd = 8'h00;
      if (wb.wb_addr == UART_ADDR_STATUS) begin
         rd[ST_TX_BUSY]  = (poll_cnt < busy_until);
         rd[ST_RX_AVAIL] = (rx_set != rx_clr);
      end else if (wb.wb_addr == UART_ADDR_RX) begin
         rd = slv_rx;
      end
   end
   assign wb.wb_data_in = rd;

   always @(posedge clk) begin
      if (wb.wb_stb && wb.wb_ack && !wb.wb_we) begin
         if (wb.wb_addr == UART_ADDR_STATUS) poll_cnt <= poll_cnt + 1;
         if (wb.wb_addr == UART_ADDR_RX)     rx_clr   <= rx_clr + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic ev_t mk(input ev_kind_t k, input logic [1:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   task automatic observe(input ev_kind_t k, input logic [1:0] a, input logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got %s addr=%0d data=0x%02h want none", k.name(), a, d);
      end else begin
         e = exp_q.pop_front();
         check({"event_", e.kind.name()}, 32'({k, a, d}), 32'({e.kind, e.addr, e.data}));
      end
   endtask

   // monitor: every DUT output event is matched against the expected queue
   always @(negedge clk) begin
      if (!reset) begin
         if (wb.wb_stb && wb.wb_ack && wb.wb_we) observe(EV_WR, wb.wb_addr, wb.wb_data_out);
         if (tx_ready)    observe(EV_TXR, 2'd0, 8'h00);
         if (rx_valid)    observe(EV_RXV, 2'd0, rx_data);
         if (timeout_err) observe(EV_TMO, 2'd0, 8'h00);
      end
   end

   task automatic wait_rise(input logic [1:0] a, output int t);
      bit seen_low;
      seen_low = !wb.wb_stb;
      t = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!wb.wb_stb) seen_low = 1'b1;
         else if (seen_low && wb.wb_addr == a) begin
            t = cyc;
            return;
         end
      end
   endtask

   task automatic wait_txr(output int t);
      t = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            t = cyc;
            return;
         end
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, tw, w;

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({wb.wb_stb, wb.wb_we, tx_ready, rx_valid, timeout_err,
                 wb.wb_addr, wb.wb_data_out, rx_data}), 32'd0);
      reset = 1'b0;

      // idle polling period = POLL_GAP + 3
      wait_rise(UART_ADDR_STATUS, t0);
      wait_rise(UART_ADDR_STATUS, t1);
      wait_rise(UART_ADDR_STATUS, t2);
      check("poll_period_1", 32'(t1 - t0), 32'(GAP_N + 3));
      check("poll_period_2", 32'(t2 - t1), 32'(GAP_N + 3));

      // single TX byte, best-case latency; tx_valid/tx_data change after capture
      wait_rise(UART_ADDR_STATUS, t0);
      exp_q.push_back(mk(EV_WR, UART_ADDR_TX, 8'h41));
      exp_q.push_back(mk(EV_TXR, 2'd0, 8'h00));
      tx_data  = 8'h41;
      tx_valid = 1'b1;
      wait_rise(UART_ADDR_TX, tw);
      check("tx_wr_latency", 32'(tw - t0), 32'd2);
      tx_valid = 1'b0;
      tx_data  = 8'hFF;
      wait_txr(t1);
      check("tx_ready_latency", 32'(t1 - t0), 32'd3);
      check("stb_low_after_ack", 32'(wb.wb_stb), 32'd0);
      drain("drain_tx41");

      // three busy polls, then write after the first non-busy poll
      busy_until = poll_cnt + 3;
      exp_q.push_back(mk(EV_WR, UART_ADDR_TX, 8'h5A));
      exp_q.push_back(mk(EV_TXR, 2'd0, 8'h00));
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      wait_txr(t1);
      tx_valid = 1'b0;
      check("write_after_busy", 32'(poll_cnt), 32'(busy_until + 1));
      drain("drain_busy");

      // status 0x03: RX read first, TX write on a later poll
      slv_rx = 8'hC3;
      rx_set = rx_set + 1;
      busy_until = poll_cnt + 1;
      exp_q.push_back(mk(EV_RXV, 2'd0, 8'hC3));
      exp_q.push_back(mk(EV_WR, UART_ADDR_TX, 8'h96));
      exp_q.push_back(mk(EV_TXR, 2'd0, 8'h00));
      tx_data  = 8'h96;
      tx_valid = 1'b1;
      wait_txr(t1);
      tx_valid = 1'b0;
      check("rx_data_held", 32'(rx_data), 32'hC3);
      drain("drain_rx_tx");

      // slave never acks: strobe width, timeout pulse, retry, byte stays pending
      stall_all = 1'b1;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      exp_q.push_back(mk(EV_TMO, 2'd0, 8'h00));
      exp_q.push_back(mk(EV_TMO, 2'd0, 8'h00));
      wait_rise(UART_ADDR_STATUS, t0);
      w = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!wb.wb_stb) break;
         w++;
      end
      check("stb_width_timeout", 32'(w), 32'(ACK_TO));
      wait_rise(UART_ADDR_STATUS, t1);
      check("poll_retry_time", 32'(t1 - t0), 32'(ACK_TO + GAP_N + 1));
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!wb.wb_stb) break;
      end
      stall_all = 1'b0;
      exp_q.push_back(mk(EV_WR, UART_ADDR_TX, 8'h3C));
      exp_q.push_back(mk(EV_TXR, 2'd0, 8'h00));
      wait_txr(t1);
      tx_valid = 1'b0;
      drain("drain_timeout");

      // reset during a stalled TX write
      stall_wr = 1'b1;
      tx_data  = 8'hE7;
      tx_valid = 1'b1;
      wait_rise(UART_ADDR_TX, tw);
      check("stalled_write_seen", 32'(tw >= 0), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("reset_drops_stb", 32'(wb.wb_stb), 32'd0);
      @(negedge clk);
      check("reset_no_pulses", 32'({tx_ready, rx_valid, timeout_err}), 32'd0);
      reset    = 1'b0;
      stall_wr = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      check("restart_poll", 32'({wb.wb_stb, wb.wb_we, wb.wb_addr}), 32'({1'b1, 1'b0, UART_ADDR_STATUS}));
      repeat (30) @(negedge clk);
      drain("drain_final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Wishbone-style bus initiator that drives the UART core's register port on behalf of on-chip logic. It polls the UART status register and writes bytes taken from a valid/ready stream into the TX data register. It reads received bytes from the RX data register and presents them on a one-cycle-valid output stream. It sits between user logic and the `uart` instance, on the UART's bus clock domain.

## Interface
Parameters:
- `ACK_TIMEOUT`, 15: cycles to wait for `wb_ack` before abandoning a bus cycle (1..255).
- `POLL_GAP`, 4: idle cycles between consecutive status polls (0..255).

Ports:
- `clk`  in  1  single clock, also the bus clock.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  `tx_data` is valid; held until accepted.
- `tx_ready`  out  1  one-cycle accept pulse; byte was written to the UART.
- `rx_data`  out  8  received byte; holds its value between pulses.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new.
- `timeout_err`  out  1  one-cycle pulse when a bus cycle times out.
- `wb_addr`  out  2  register address.
- `wb_data_out`  out  8  write data to the UART.
- `wb_data_in`  in  8  read data from the UART.
- `wb_we`  out  1  1 = write, 0 = read.
- `wb_stb`  out  1  cycle strobe / chip select.
- `wb_ack`  in  1  slave acknowledge.

## Operation
UART register map (constants):
- addr 0: TX_DATA (write).
- addr 1: STATUS (read). Bit 0 = `tx_busy`, bit 1 = `rx_avail`.
- addr 2: RX_DATA (read). Reading it clears `rx_avail` in the slave.

FSM states: IDLE, POLL, DECIDE, TX_WR, RX_RD, GAP.
- IDLE -> POLL unconditionally, on the next cycle.
- POLL: read addr 1; latch `wb_data_in` into `status_q` on ack; -> DECIDE.
- DECIDE applies these rules in order:
  - If `status_q[1]`, go to RX_RD. RX has priority over TX.
  - Else if `tx_valid && !status_q[0]`, capture `tx_data` into `wb_data_out` and go to TX_WR.
  - Else go to GAP.
- TX_WR: write addr 0. On ack, pulse `tx_ready`, then -> GAP.
- RX_RD: read addr 2. On ack, `rx_data <= wb_data_in` and pulse `rx_valid`, then -> GAP.
- GAP: count `POLL_GAP` cycles, then -> POLL. With `POLL_GAP`=0, GAP lasts 1 cycle.
- Timeout applies in any bus state (POLL, TX_WR, RX_RD). If `ACK_TIMEOUT` cycles pass with `wb_ack` low:
  - drop `wb_stb`;
  - pulse `timeout_err`;
  - go to GAP.
  - No `tx_ready` or `rx_valid` is issued; the TX byte stays pending and is retried.
- `tx_data` may change once `tx_valid` is high. The value captured in DECIDE is what gets transmitted.
- `tx_valid` dropping after capture does not abort TX_WR. The write completes and `tx_ready` still pulses.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE;
  - `wb_stb`, `wb_we`, `tx_ready`, `rx_valid`, `timeout_err` = 0;
  - `wb_addr`, `wb_data_out`, `rx_data` = 0.
- Bus cycle:
  - `wb_stb`, `wb_addr`, `wb_we` and `wb_data_out` are asserted on the clock edge that enters the bus state.
  - They are held stable until `wb_ack` is sampled high.
  - `wb_stb` is deasserted on the edge that samples ack, so back-to-back strobes never occur; there is at least 1 idle cycle.
- A zero-wait slave (ack on the first strobe cycle) gives a 1-cycle bus phase.
- `wb_ack` arriving while `wb_stb` is low is ignored.
- Timeout counter:
  - cleared on bus-state entry;
  - times out when it reaches `ACK_TIMEOUT` with no ack;
  - an ack and a timeout in the same cycle resolve as ack.
- Best-case TX latency, from `tx_valid` rising in GAP/IDLE with a zero-wait slave: POLL(1) + DECIDE(1) + TX_WR(1). `tx_ready` is high 3 cycles after POLL entry.
- `tx_ready` and `rx_valid` are mutually exclusive. Each is high for exactly 1 cycle.
- Synchronous `reset` mid-cycle:
  - `wb_stb` drops on the next edge;
  - any pending capture is discarded;
  - no pulses are emitted.

## Structure
- Shared package `uart_pkg`:
  - register address constants `UART_ADDR_TX`=0, `UART_ADDR_STATUS`=1, `UART_ADDR_RX`=2;
  - status bit indices `ST_TX_BUSY`=0, `ST_RX_AVAIL`=1;
  - the FSM state enum.
- Natural sub-module: `wb_cycle_ctl`. It owns the strobe/ack/timeout handshake for one bus transaction (start, addr, we, data in; done, rdata, timeout out). The top holds the poll/decide FSM.

## Test plan
- Reset, then idle with a slave that returns status 0x00 and acks with zero wait:
  - polls repeat every `POLL_GAP`+3 cycles;
  - no `tx_ready`, `rx_valid` or `timeout_err` pulses.
- `tx_valid`=1, `tx_data`=0x41, status=0x00:
  - exactly one write with addr 0 and data 0x41;
  - one `tx_ready` pulse;
  - `wb_stb` low the cycle after ack.
- Status=0x01 (busy) for 3 polls, then 0x00, with `tx_valid`=1 and 0x5A:
  - no write during the busy polls;
  - one write of 0x5A after the first non-busy poll.
- Status=0x03 with `tx_valid`=1, RX_DATA=0xC3:
  - RX read happens first;
  - `rx_valid` pulses with `rx_data`=0xC3;
  - the TX write follows on a later poll.
- Slave never acks, `ACK_TIMEOUT`=15:
  - `wb_stb` is high for exactly 15 cycles;
  - `timeout_err` pulses once;
  - the next poll is retried;
  - the pending TX byte is still unaccepted.
- `reset` asserted during TX_WR with the slave stalling:
  - `wb_stb` is 0 on the next edge;
  - no `tx_ready` pulse;
  - the FSM restarts from IDLE.
